// File: rtl/core_alu_signals.sv
// Control-word layout shared between the core ALU and the blocks that drive it.
package core_alu_signals;

    localparam int unsigned CtlSelectAdc  = 0;
    localparam int unsigned CtlSelectRol  = 1;
    localparam int unsigned CtlSelectRor  = 2;
    localparam int unsigned CtlClearCarry = 3;
    localparam int unsigned CtlSetCarry   = 4;
    localparam int unsigned CtlInvICarry  = 5;
    localparam int unsigned CtlClearRhs   = 6;
    localparam int unsigned CtlInvertRhs  = 7;
    localparam int unsigned CtlResultSign = 8;
    localparam int unsigned CtlResultZero = 9;
    localparam int unsigned ControlWidth  = 10;

    typedef logic [ControlWidth-1:0] control_type;

endpackage

// File: rtl/core_rmw_sequencer_pkg.sv
// Types and the op-to-control mapping for the read-modify-write sequencer.
package core_rmw_signals;

    import core_alu_signals::*;

    // Codes 6 and 7 are deliberately unnamed: they pass the operand through.
    typedef enum logic [2:0] {
        RmwAsl = 3'd0,
        RmwLsr = 3'd1,
        RmwRol = 3'd2,
        RmwRor = 3'd3,
        RmwInc = 3'd4,
        RmwDec = 3'd5
    } rmw_op_type;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDummy = 2'd2,
        StWrite = 2'd3
    } rmw_state_type;

    // ALU control word for each memory RMW op; all zeros means result = lhs.
    function automatic control_type rmw_control(rmw_op_type op);
        control_type c;
        c = '0;
        case (op)
            RmwAsl, RmwRol: begin
                c[CtlSelectRol]  = 1'b1;
                c[CtlClearCarry] = (op == RmwAsl);
                c[CtlSetCarry]   = 1'b1;
                c[CtlResultSign] = 1'b1;
                c[CtlResultZero] = 1'b1;
            end
            RmwLsr, RmwRor: begin
                c[CtlSelectRor]  = 1'b1;
                c[CtlClearCarry] = (op == RmwLsr);
                c[CtlSetCarry]   = 1'b1;
                c[CtlResultSign] = 1'b1;
                c[CtlResultZero] = 1'b1;
            end
            RmwInc: begin
                // Carry-in forced to 1 by clearing then inverting it.
                c[CtlSelectAdc]  = 1'b1;
                c[CtlClearRhs]   = 1'b1;
                c[CtlClearCarry] = 1'b1;
                c[CtlInvICarry]  = 1'b1;
                c[CtlResultSign] = 1'b1;
                c[CtlResultZero] = 1'b1;
            end
            RmwDec: begin
                // lhs + $FF + 0 is lhs - 1.
                c[CtlSelectAdc]  = 1'b1;
                c[CtlClearRhs]   = 1'b1;
                c[CtlInvertRhs]  = 1'b1;
                c[CtlClearCarry] = 1'b1;
                c[CtlResultSign] = 1'b1;
                c[CtlResultZero] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/core_rmw_sequencer.sv
// Sequences the ALU for 2A03 memory RMW instructions: read, optional dummy
// write-back of the old value, then the final write with a single flag update.
// Option: CORE_RMW_DUMMY_WRITE_EN keeps the DUMMY state (three bus accesses);
// left undefined, READ goes straight to WRITE (two bus accesses).
module core_rmw_sequencer
    import core_alu_signals::*;
    import core_rmw_signals::*;
(
    input  logic        I_clock,
    input  logic        I_reset_n,
    input  logic        I_start,
    input  logic [2:0]  I_op,
    input  logic [15:0] I_addr,
    input  logic        I_ready,
    input  logic [7:0]  I_data,
    input  logic [7:0]  I_alu_result,
    output logic [15:0] O_addr,
    output logic        O_rw,
    output logic [7:0]  O_wdata,
    output control_type O_alu_control,
    output logic [7:0]  O_alu_lhs,
    output logic        O_alu_mask_p,
    output logic        O_busy,
    output logic        O_done
);

    rmw_state_type state_q;
    logic [15:0]   addr_q;
    logic [7:0]    operand_q;
    control_type   ctrl_q;
    logic          rw_q;
    logic          mask_p_q;
    logic          busy_q;
    logic          done_q;

    // State machine with every control output registered alongside the state.
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            operand_q <= '0;
            ctrl_q    <= '0;
            rw_q      <= 1'b1;
            mask_p_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (I_start) begin
                        state_q <= StRead;
                        addr_q  <= I_addr;
                        ctrl_q  <= rmw_control(rmw_op_type'(I_op));
                        rw_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StRead: begin
                    if (I_ready) begin
                        operand_q <= I_data;
                        rw_q      <= 1'b0;
`ifdef CORE_RMW_DUMMY_WRITE_EN
                        state_q   <= StDummy;
`else
                        state_q   <= StWrite;
                        // Pass-through codes have a zero word and never touch flags.
                        mask_p_q  <= |ctrl_q;
`endif
                    end
                end
`ifdef CORE_RMW_DUMMY_WRITE_EN
                StDummy: begin
                    state_q  <= StWrite;
                    mask_p_q <= |ctrl_q;
                end
`endif
                StWrite: begin
                    state_q  <= StIdle;
                    rw_q     <= 1'b1;
                    mask_p_q <= 1'b0;
                    ctrl_q   <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bus write data: new value in WRITE, otherwise the unmodified operand.
    always_comb begin
        O_wdata = (state_q == StWrite) ? I_alu_result : operand_q;
    end

    assign O_addr        = addr_q;
    assign O_rw          = rw_q;
    assign O_alu_control = ctrl_q;
    assign O_alu_lhs     = operand_q;
    assign O_alu_mask_p  = mask_p_q;
    assign O_busy        = busy_q;
    assign O_done        = done_q;

endmodule

// File: tb/tb_core_rmw_sequencer.sv
// Scoreboard bench for core_rmw_sequencer: stimulus pushes the expected
// per-cycle bus/flag trace, a negedge monitor pops and compares.
module tb_core_rmw_sequencer;
    import core_alu_signals::*;

    logic        I_clock = 1'b0;
    logic        I_reset_n;
    logic        I_start;
    logic [2:0]  I_op;
    logic [15:0] I_addr;
    logic        I_ready;
    logic [7:0]  I_data;
    logic [7:0]  I_alu_result;
    logic [15:0] O_addr;
    logic        O_rw;
    logic [7:0]  O_wdata;
    control_type O_alu_control;
    logic [7:0]  O_alu_lhs;
    logic        O_alu_mask_p;
    logic        O_busy;
    logic        O_done;

    core_rmw_sequencer dut (
        .I_clock      (I_clock),
        .I_reset_n    (I_reset_n),
        .I_start      (I_start),
        .I_op         (I_op),
        .I_addr       (I_addr),
        .I_ready      (I_ready),
        .I_data       (I_data),
        .I_alu_result (I_alu_result),
        .O_addr       (O_addr),
        .O_rw         (O_rw),
        .O_wdata      (O_wdata),
        .O_alu_control(O_alu_control),
        .O_alu_lhs    (O_alu_lhs),
        .O_alu_mask_p (O_alu_mask_p),
        .O_busy       (O_busy),
        .O_done       (O_done)
    );

    always #5 I_clock = ~I_clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Memory: static contents, read data is junk while RDY is low.
    logic [7:0] mem [65536];
    logic [7:0] junk = 8'h5a;
    assign I_data = I_ready ? mem[O_addr] : junk;

    // Stand-in ALU that interprets the control word; flags live here.
    logic fc = 1'b0, fn = 1'b0, fz = 1'b0;
    logic alu_co;
    always_comb begin
        logic       cin;
        logic [7:0] rhs;
        logic [8:0] sum;
        cin = (O_alu_control[CtlClearCarry] ? 1'b0 : fc) ^ O_alu_control[CtlInvICarry];
        rhs = O_alu_control[CtlInvertRhs] ? 8'hff : 8'h00;
        sum = {1'b0, O_alu_lhs} + {1'b0, rhs} + {8'd0, cin};
        if (O_alu_control[CtlSelectAdc]) begin
            I_alu_result = sum[7:0];
            alu_co       = sum[8];
        end else if (O_alu_control[CtlSelectRol]) begin
            I_alu_result = {O_alu_lhs[6:0], cin};
            alu_co       = O_alu_lhs[7];
        end else if (O_alu_control[CtlSelectRor]) begin
            I_alu_result = {cin, O_alu_lhs[7:1]};
            alu_co       = O_alu_lhs[0];
        end else begin
            I_alu_result = O_alu_lhs;
            alu_co       = cin;
        end
    end

    always @(posedge I_clock) begin
        if (O_alu_mask_p) begin
            if (O_alu_control[CtlSetCarry])   fc <= alu_co;
            if (O_alu_control[CtlResultSign]) fn <= I_alu_result[7];
            if (O_alu_control[CtlResultZero]) fz <= (I_alu_result == 8'h00);
        end
    end

    // Reference model: flag state and op semantics in plain arithmetic.
    logic mc = 1'b0, mn = 1'b0, mz = 1'b0;

    task automatic model(input logic [2:0] op, input logic [7:0] v, output logic [7:0] r);
        case (op)
            3'd0: begin r = v << 1;        mc = v[7]; end
            3'd1: begin r = v >> 1;        mc = v[0]; end
            3'd2: begin r = {v[6:0], mc};  mc = v[7]; end
            3'd3: begin r = {mc, v[7:1]};  mc = v[0]; end
            3'd4: r = v + 8'd1;
            3'd5: r = v - 8'd1;
            default: r = v;
        endcase
        if (op < 3'd6) begin
            mn = r[7];
            mz = (r == 8'h00);
        end
    endtask

    typedef struct {
        logic        busy;
        logic        first;
        logic [15:0] addr;
        logic        rw;
        logic        chk_data;
        logic [7:0]  data;
        logic        chk_lhs;
        logic [7:0]  lhs;
        logic        mask;
        logic        ctl_zero;
        logic        c, n, z;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(logic busy, logic first, logic [15:0] addr, logic rw,
                                logic chk_data, logic [7:0] data, logic chk_lhs,
                                logic [7:0] lhs, logic mask, logic ctl_zero);
        exp_t e;
        e.busy = busy; e.first = first; e.addr = addr; e.rw = rw;
        e.chk_data = chk_data; e.data = data; e.chk_lhs = chk_lhs; e.lhs = lhs;
        e.mask = mask; e.ctl_zero = ctl_zero; e.c = 1'b0; e.n = 1'b0; e.z = 1'b0;
        return e;
    endfunction

    logic hold = 1'b1;
    control_type ctl_ref = '0;

    // Monitor: one expected entry per busy or done cycle.
    always @(negedge I_clock) begin
        exp_t e;
        if (!hold && I_reset_n) begin
            if (O_busy || O_done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", {30'd0, O_busy, O_done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("busy", O_busy, e.busy);
                    chk("done", O_done, !e.busy);
                    chk("rw", O_rw, e.rw);
                    chk("mask_p", O_alu_mask_p, e.mask);
                    if (e.busy) begin
                        chk("addr", O_addr, e.addr);
                        if (e.first) ctl_ref = O_alu_control;
                        else chk("ctl_hold", O_alu_control, ctl_ref);
                        if (e.ctl_zero) chk("ctl_passthru", O_alu_control, 0);
                        if (e.chk_data) chk("wdata", O_wdata, e.data);
                        if (e.chk_lhs) chk("alu_lhs", O_alu_lhs, e.lhs);
                    end else begin
                        chk("ctl_done", O_alu_control, 0);
                        chk("flag_c", fc, e.c);
                        chk("flag_n", fn, e.n);
                        chk("flag_z", fz, e.z);
                    end
                end
            end else begin
                chk("idle_rw", O_rw, 1);
                chk("idle_mask", O_alu_mask_p, 0);
                chk("idle_ctl", O_alu_control, 0);
            end
        end
    end

    // Issue one op from a cycle where the DUT is idle; returns in its done cycle.
    task automatic do_op(input logic [2:0] op, input logic [15:0] addr, input int stalls);
        exp_t e;
        logic [7:0] v, r;
        v = mem[addr];
        model(op, v, r);
        for (int i = 0; i <= stalls; i++)
            exp_q.push_back(mk(1, i == 0, addr, 1, 0, 8'h00, 0, 8'h00, 0, op >= 3'd6));
`ifdef CORE_RMW_DUMMY_WRITE_EN
        exp_q.push_back(mk(1, 0, addr, 0, 1, v, 1, v, 0, op >= 3'd6));
`endif
        exp_q.push_back(mk(1, 0, addr, 0, 1, r, 1, v, op < 3'd6, op >= 3'd6));
        e = mk(0, 0, addr, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        e.c = mc; e.n = mn; e.z = mz;
        exp_q.push_back(e);

        I_start = 1'b1;
        I_op    = op;
        I_addr  = addr;
        I_ready = 1'($urandom_range(0, 1));
        @(posedge I_clock); #1;
        for (int i = 0; i <= stalls; i++) begin
            I_ready = (i < stalls) ? 1'b0 : 1'b1;
            I_start = 1'($urandom_range(0, 1));
            I_op    = 3'($urandom);
            I_addr  = 16'($urandom);
            junk    = 8'($urandom);
            @(posedge I_clock); #1;
        end
`ifdef CORE_RMW_DUMMY_WRITE_EN
        I_ready = 1'($urandom_range(0, 1));
        I_start = 1'($urandom_range(0, 1));
        I_op    = 3'($urandom);
        @(posedge I_clock); #1;
`endif
        I_ready = 1'($urandom_range(0, 1));
        I_start = 1'($urandom_range(0, 1));
        I_addr  = 16'($urandom);
        @(posedge I_clock); #1;
        I_start = 1'b0;
        I_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            I_start = 1'b0;
            I_op    = 3'($urandom);
            I_addr  = 16'($urandom);
            @(posedge I_clock); #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rw"}, O_rw, 1);
        chk({tag, "_busy"}, O_busy, 0);
        chk({tag, "_done"}, O_done, 0);
        chk({tag, "_mask"}, O_alu_mask_p, 0);
        chk({tag, "_ctl"}, O_alu_control, 0);
        chk({tag, "_addr"}, O_addr, 0);
        chk({tag, "_lhs"}, O_alu_lhs, 0);
        chk({tag, "_wdata"}, O_wdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        I_reset_n = 1'b0;
        I_start   = 1'b0;
        I_op      = 3'd0;
        I_addr    = 16'd0;
        I_ready   = 1'b1;
        #12;
        chk_reset_outputs("reset");
        @(negedge I_clock) I_reset_n = 1'b1;
        @(posedge I_clock); #1;
        hold = 1'b0;
        idle(1);

        // Directed cases.
        mem[16'h0200] = 8'h81; do_op(3'd0, 16'h0200, 0); idle(1);
        mem[16'h0010] = 8'h01; do_op(3'd5, 16'h0010, 0); idle(1);
        mem[16'h00ff] = 8'hff; do_op(3'd4, 16'h00ff, 2); idle(2);
        mem[16'h0400] = 8'h02; do_op(3'd3, 16'h0400, 0); idle(2);

        // Asynchronous reset in the middle of an operation.
        hold = 1'b1;
        I_start = 1'b1; I_op = 3'd0; I_addr = 16'h0300; I_ready = 1'b1;
        @(posedge I_clock); #1;
        I_start = 1'b0;
`ifdef CORE_RMW_DUMMY_WRITE_EN
        @(posedge I_clock); #1;
        chk("pre_reset_dummy_rw", O_rw, 0);
`else
        chk("pre_reset_read_rw", O_rw, 1);
`endif
        chk("pre_reset_busy", O_busy, 1);
        #2 I_reset_n = 1'b0;
        #1 chk_reset_outputs("abort");
        for (int i = 0; i < 2; i++) begin
            @(posedge I_clock); #1;
            chk("abort_hold_rw", O_rw, 1);
            chk("abort_hold_busy", O_busy, 0);
        end
        @(negedge I_clock) I_reset_n = 1'b1;
        @(posedge I_clock); #1;
        chk("abort_flag_c", fc, mc);
        chk("abort_flag_n", fn, mn);
        chk("abort_flag_z", fz, mz);
        hold = 1'b0;
        do_op(3'd0, 16'h0300, 1); idle(1);

        // Start held high: each next request accepted in the done cycle.
        do_op(3'd2, 16'h1234, 0);
        do_op(3'd1, 16'h4321, 1);
        do_op(3'd6, 16'h0042, 0);
        do_op(3'd7, 16'h0043, 0);
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 80; k++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 3)));
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
